// File: rtl/dp_run_ctrl.sv
// Run-control scheduler for the pipelined MIPS datapath: run/stop/step/reset commands,
// registered clock-enable and reset, halt capture and enabled-cycle counter.
// Optional RUN watchdog is built when DP_RUN_CTRL_WDOG_EN is defined.
module dp_run_ctrl #(
  parameter int CNT_W    = 32,
  parameter int STEP_W   = 16,
  parameter int RST_CYC  = 4,
  parameter int WDOG_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_steps,
  output logic              cmd_ready,
  output logic              cmd_err,
  input  logic              dp_halt,
  output logic              dp_en,
  output logic              dp_rst,
  output logic              busy,
  output logic              done,
  output logic              halted,
  output logic              wdog_trip,
  output logic [CNT_W-1:0]  cycle_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_DPRST  = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  localparam logic [1:0]        OP_STOP    = 2'b00;
  localparam logic [1:0]        OP_RUN     = 2'b01;
  localparam logic [1:0]        OP_STEP    = 2'b10;
  localparam logic [1:0]        OP_DPRESET = 2'b11;
  localparam int                RST_W      = $clog2(RST_CYC + 1);
  localparam logic [STEP_W-1:0] STEP_ONE   = STEP_W'(1);
  localparam logic [RST_W-1:0]  RST_ONE    = RST_W'(1);
  localparam logic [RST_W-1:0]  RST_LOAD   = RST_W'(RST_CYC);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

  state_t            state_r, state_nx_s;
  logic [STEP_W-1:0] step_left_r, step_left_nx_s;
  logic [RST_W-1:0]  rst_left_r, rst_left_nx_s;
  logic              accept_s, halt_s, wdog_hit_s, cnt_clr_s;
  logic              done_nx_s, err_nx_s, trip_nx_s;
  logic              ready_nx_s, en_nx_s, dprst_nx_s, halted_nx_s;

  assign accept_s = cmd_valid && cmd_ready;
  assign halt_s   = dp_halt && dp_en && !dp_rst;

`ifdef DP_RUN_CTRL_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYC + 1);
  logic [WD_W-1:0] wdog_cnt_r;

  assign wdog_hit_s = (state_r == S_RUN) && (wdog_cnt_r == WD_W'(WDOG_CYC - 1));

  // Consecutive RUN cycle counter; held at zero outside RUN so every entry starts fresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt_r <= '0;
    end else if (state_r != S_RUN) begin
      wdog_cnt_r <= '0;
    end else begin
      wdog_cnt_r <= wdog_cnt_r + WD_W'(1);
    end
  end
`else
  assign wdog_hit_s = 1'b0;
`endif

  // Next-state and next-output decode; halt outranks STOP, which outranks the watchdog.
  always_comb begin
    state_nx_s     = state_r;
    step_left_nx_s = step_left_r;
    rst_left_nx_s  = rst_left_r;
    done_nx_s      = 1'b0;
    err_nx_s       = 1'b0;
    trip_nx_s      = 1'b0;
    cnt_clr_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          case (cmd_op)
            OP_RUN: state_nx_s = S_RUN;
            OP_STEP: begin
              state_nx_s     = S_STEP;
              step_left_nx_s = (cmd_steps == '0) ? STEP_ONE : cmd_steps;
            end
            OP_DPRESET: begin
              state_nx_s    = S_DPRST;
              rst_left_nx_s = RST_LOAD;
              cnt_clr_s     = 1'b1;
            end
            default: err_nx_s = 1'b1;
          endcase
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (halt_s) begin
          state_nx_s = S_HALTED;
          done_nx_s  = 1'b1;
          err_nx_s   = accept_s;
        end else if (accept_s && (cmd_op == OP_STOP)) begin
          state_nx_s = S_IDLE;
          done_nx_s  = 1'b1;
        end else if (wdog_hit_s) begin
          state_nx_s = S_IDLE;
          done_nx_s  = 1'b1;
          trip_nx_s  = 1'b1;
          err_nx_s   = accept_s;
        end else begin
          err_nx_s = accept_s;
        end
      end
      S_STEP: begin
        step_left_nx_s = step_left_r - STEP_ONE;
        if (halt_s) begin
          state_nx_s = S_HALTED;
          done_nx_s  = 1'b1;
        end else if (step_left_r == STEP_ONE) begin
          state_nx_s = S_IDLE;
          done_nx_s  = 1'b1;
        end else begin
          state_nx_s = S_STEP;
        end
      end
      S_DPRST: begin
        rst_left_nx_s = rst_left_r - RST_ONE;
        if (rst_left_r == RST_ONE) begin
          state_nx_s = S_IDLE;
        end else begin
          state_nx_s = S_DPRST;
        end
      end
      S_HALTED: begin
        if (accept_s && (cmd_op == OP_DPRESET)) begin
          state_nx_s    = S_DPRST;
          rst_left_nx_s = RST_LOAD;
          cnt_clr_s     = 1'b1;
        end else begin
          err_nx_s = accept_s;
        end
      end
      default: state_nx_s = S_IDLE;
    endcase
  end

  // Level outputs are a decode of the next state so they land on the same edge as it.
  always_comb begin
    ready_nx_s  = (state_nx_s == S_IDLE) || (state_nx_s == S_RUN) || (state_nx_s == S_HALTED);
    en_nx_s     = (state_nx_s == S_RUN) || (state_nx_s == S_STEP) || (state_nx_s == S_DPRST);
    dprst_nx_s  = (state_nx_s == S_DPRST);
    halted_nx_s = (state_nx_s == S_HALTED);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      step_left_r <= '0;
      rst_left_r  <= '0;
      cmd_ready   <= 1'b1;
      cmd_err     <= 1'b0;
      dp_en       <= 1'b0;
      dp_rst      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      halted      <= 1'b0;
      wdog_trip   <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      step_left_r <= step_left_nx_s;
      rst_left_r  <= rst_left_nx_s;
      cmd_ready   <= ready_nx_s;
      cmd_err     <= err_nx_s;
      dp_en       <= en_nx_s;
      dp_rst      <= dprst_nx_s;
      busy        <= en_nx_s;
      done        <= done_nx_s;
      halted      <= halted_nx_s;
      wdog_trip   <= trip_nx_s;
    end
  end

  // Saturating count of enabled, non-reset datapath cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else if (cnt_clr_s) begin
      cycle_cnt <= '0;
    end else if (dp_en && !dp_rst && (cycle_cnt != {CNT_W{1'b1}})) begin
      cycle_cnt <= cycle_cnt + CNT_ONE;
    end else begin
      cycle_cnt <= cycle_cnt;
    end
  end

endmodule

// File: tb/tb_dp_run_ctrl.sv
// Directed bench for dp_run_ctrl: a vector table for reset/STEP/STOP/DPRESET,
// then hand sequences for halt, long RUN, mid-STEP reset and the watchdog.
module tb_dp_run_ctrl;
  localparam int CNT_W    = 32;
  localparam int STEP_W   = 16;
  localparam int RST_CYC  = 4;
  localparam int WDOG_CYC = 50;
`ifdef DP_RUN_CTRL_WDOG_EN
  localparam int STOP_LEN = 40;
`else
  localparam int STOP_LEN = 100;
`endif

  localparam logic [1:0] OP_STOP = 2'b00, OP_RUN = 2'b01, OP_STEP = 2'b10, OP_DPRESET = 2'b11;

  // flag order: {cmd_ready, cmd_err, dp_en, dp_rst, busy, done, halted, wdog_trip}
  localparam logic [7:0] F_IDLE  = 8'b1000_0000;
  localparam logic [7:0] F_EN    = 8'b0010_1000;
  localparam logic [7:0] F_RUN   = 8'b1010_1000;
  localparam logic [7:0] F_DONE  = 8'b1000_0100;
  localparam logic [7:0] F_ERR   = 8'b1100_0000;
  localparam logic [7:0] F_DPRST = 8'b0011_1000;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cmd_valid = 1'b0;
  logic [1:0]        cmd_op = 2'b00;
  logic [STEP_W-1:0] cmd_steps = '0;
  logic              dp_halt = 1'b0;
  logic              cmd_ready, cmd_err, dp_en, dp_rst, busy, done, halted, wdog_trip;
  logic [CNT_W-1:0]  cycle_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dp_run_ctrl #(.CNT_W(CNT_W), .STEP_W(STEP_W), .RST_CYC(RST_CYC), .WDOG_CYC(WDOG_CYC)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_steps(cmd_steps),
    .cmd_ready(cmd_ready), .cmd_err(cmd_err), .dp_halt(dp_halt), .dp_en(dp_en),
    .dp_rst(dp_rst), .busy(busy), .done(done), .halted(halted), .wdog_trip(wdog_trip),
    .cycle_cnt(cycle_cnt)
  );

  typedef struct {
    logic              valid;
    logic [1:0]        op;
    logic [STEP_W-1:0] steps;
    logic              halt;
    logic              rst;
    logic [7:0]        exp_f;
    logic [CNT_W-1:0]  exp_cnt;
  } vec_t;

  vec_t vecs[16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] ef, input logic [CNT_W-1:0] ec);
    logic [7:0] af;
    af = {cmd_ready, cmd_err, dp_en, dp_rst, busy, done, halted, wdog_trip};
    checks++;
    if ({af, cycle_cnt} !== {ef, ec}) begin
      errors++;
      $display("FAIL %s: flags=%b cnt=%0d, expected flags=%b cnt=%0d", name, af, cycle_cnt, ef, ec);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [STEP_W-1:0] n);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_steps = n;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int en_n, trip_n, done_n;

    vecs[0]  = '{1'b0, OP_STOP,    16'd0, 1'b0, 1'b1, F_IDLE,  32'd0};
    vecs[1]  = '{1'b1, OP_STEP,    16'd5, 1'b0, 1'b0, F_EN,    32'd0};
    vecs[2]  = '{1'b0, OP_STOP,    16'd0, 1'b0, 1'b0, F_EN,    32'd1};
    vecs[3]  = '{1'b0, OP_STOP,    16'd0, 1'b0, 1'b0, F_EN,    32'd2};
    vecs[4]  = '{1'b0, OP_STOP,    16'd0, 1'b0, 1'b0, F_EN,    32'd3};
    vecs[5]  = '{1'b0, OP_STOP,    16'd0, 1'b0, 1'b0, F_EN,    32'd4};
    vecs[6]  = '{1'b0, OP_STOP,    16'd0, 1'b0, 1'b0, F_DONE,  32'd5};
    vecs[7]  = '{1'b1, OP_STEP,    16'd0, 1'b0, 1'b0, F_EN,    32'd5};
    vecs[8]  = '{1'b0, OP_STOP,    16'd0, 1'b0, 1'b0, F_DONE,  32'd6};
    vecs[9]  = '{1'b1, OP_STOP,    16'd0, 1'b0, 1'b0, F_ERR,   32'd6};
    vecs[10] = '{1'b0, OP_STOP,    16'd0, 1'b0, 1'b0, F_IDLE,  32'd6};
    vecs[11] = '{1'b1, OP_DPRESET, 16'd0, 1'b0, 1'b0, F_DPRST, 32'd0};
    vecs[12] = '{1'b0, OP_STOP,    16'd0, 1'b0, 1'b0, F_DPRST, 32'd0};
    vecs[13] = '{1'b0, OP_STOP,    16'd0, 1'b0, 1'b0, F_DPRST, 32'd0};
    vecs[14] = '{1'b0, OP_STOP,    16'd0, 1'b0, 1'b0, F_DPRST, 32'd0};
    vecs[15] = '{1'b0, OP_STOP,    16'd0, 1'b0, 1'b0, F_IDLE,  32'd0};

    for (int i = 0; i < 16; i++) begin
      cmd_valid = vecs[i].valid;
      cmd_op    = vecs[i].op;
      cmd_steps = vecs[i].steps;
      dp_halt   = vecs[i].halt;
      rst       = vecs[i].rst;
      step();
      check($sformatf("vec%0d", i), vecs[i].exp_f, vecs[i].exp_cnt);
    end
    cmd_valid = 1'b0;
    rst       = 1'b0;

    // RUN, halt on the 20th enabled cycle together with a STOP
    issue(OP_RUN, 16'd0);
    check("run_start", F_RUN, 32'd0);
    for (int i = 1; i < 20; i++) step();
    check("run_cyc20", F_RUN, 32'd19);
    dp_halt = 1'b1;
    issue(OP_STOP, 16'd0);
    dp_halt = 1'b0;
    check("halt_with_stop", 8'b1100_0110, 32'd20);
    step();
    check("halted_hold", 8'b1000_0010, 32'd20);
    issue(OP_RUN, 16'd0);
    check("halted_run_err", 8'b1100_0010, 32'd20);
    issue(OP_DPRESET, 16'd0);
    check("halted_dpreset", F_DPRST, 32'd0);
    for (int i = 1; i < RST_CYC; i++) begin
      step();
      check("dprst_hold", F_DPRST, 32'd0);
    end
    step();
    check("dprst_end", F_IDLE, 32'd0);

    // RUN, then STOP after STOP_LEN enabled cycles
    issue(OP_RUN, 16'd0);
    for (int i = 1; i < STOP_LEN; i++) step();
    check("run_pre_stop", F_RUN, 32'(STOP_LEN - 1));
    issue(OP_STOP, 16'd0);
    check("run_stop", F_DONE, 32'(STOP_LEN));
    step();
    check("after_stop", F_IDLE, 32'(STOP_LEN));

    // reset in the middle of STEP 1000
    issue(OP_STEP, 16'd1000);
    for (int i = 0; i < 10; i++) step();
    check("step_mid", F_EN, 32'(STOP_LEN + 10));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_step", F_IDLE, 32'd0);
    step();
    check("rst_step_gone", F_IDLE, 32'd0);

    // watchdog
    issue(OP_RUN, 16'd0);
    en_n = 0; trip_n = 0; done_n = 0;
    for (int i = 0; i < 60; i++) begin
      en_n   += int'(dp_en);
      trip_n += int'(wdog_trip);
      done_n += int'(done && wdog_trip);
      step();
    end
`ifdef DP_RUN_CTRL_WDOG_EN
    check_int("wdog_en_cycles", en_n, WDOG_CYC);
    check_int("wdog_trip_pulses", trip_n, 1);
    check_int("wdog_done_with_trip", done_n, 1);
    check("wdog_idle", F_IDLE, 32'(WDOG_CYC));
`else
    check_int("nowdog_en_cycles", en_n, 60);
    check_int("nowdog_trip_pulses", trip_n, 0);
    check("nowdog_still_run", F_RUN, 32'd60);
    issue(OP_STOP, 16'd0);
    check("nowdog_stop", F_DONE, 32'd61);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dp_run_ctrl.md
# dp_run_ctrl

Run-control scheduler for the pipelined MIPS datapath. It accepts run, stop, step-N and datapath-reset commands from the debug unit and drives a registered clock-enable and reset to the datapath. It stops the datapath on the datapath's halt flag and keeps a count of executed datapath cycles for the register dump. It sits between the debug unit's command decoder and the datapath's clock/reset inputs.

## Interface
- `CNT_W`, 32: width of `cycle_cnt`.
- `STEP_W`, 16: width of `cmd_steps`.
- `RST_CYC`, 4: number of cycles `dp_rst` is held during a datapath reset (≥1).
- `WDOG_CYC`, 1_000_000: watchdog limit in consecutive RUN cycles (used only with the macro).

Ports:
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_op`  in  2  00 STOP, 01 RUN, 10 STEP, 11 DPRESET.
- `cmd_steps`  in  STEP_W  step count for STEP.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`.
- `cmd_err`  out  1  one-cycle pulse: accepted command was ignored.
- `dp_halt`  in  1  datapath halt flag.
- `dp_en`  out  1  datapath clock enable.
- `dp_rst`  out  1  datapath reset.
- `busy`  out  1  high in RUN, STEP and DPRST.
- `done`  out  1  one-cycle pulse at the end of STEP, halt, STOP or watchdog trip.
- `halted`  out  1  high in HALTED.
- `wdog_trip`  out  1  one-cycle pulse on a watchdog abort.
- `cycle_cnt`  out  CNT_W  count of cycles with `dp_en`=1.

## Operation
- States: IDLE, RUN, STEP, DPRST, HALTED.
- Reset values: state IDLE, `cmd_ready`=1, and every other output 0, including `cycle_cnt`.
- IDLE, `cmd_ready`=1:
  - RUN goes to RUN.
  - STEP goes to STEP and loads `step_left` = `cmd_steps`; a count of 0 is treated as 1.
  - DPRESET goes to DPRST.
  - STOP pulses `cmd_err`.
- RUN, `cmd_ready`=1:
  - STOP goes to IDLE and pulses `done`.
  - Any other op pulses `cmd_err` and the state is unchanged.
- STEP, `cmd_ready`=0:
  - `step_left` decrements on every `dp_en` cycle.
  - After the last enabled cycle, the state goes to IDLE and pulses `done`.
- DPRST, `cmd_ready`=0:
  - `dp_rst`=1 and `dp_en`=1 for exactly RST_CYC cycles, so the datapath's synchronous reset is clocked in.
  - `cycle_cnt` is cleared on entry, and reset cycles are not counted.
  - The state then goes to IDLE; `done` is not pulsed.
- HALTED, `cmd_ready`=1:
  - DPRESET goes to DPRST.
  - RUN, STEP and STOP pulse `cmd_err`.
  - `halted`=1 until a DPRESET is accepted.
- Halt: if `dp_halt`=1 is sampled on a cycle where `dp_en`=1 in RUN or STEP, the state goes to HALTED and `done` pulses. The halt takes priority over STEP completion and over a STOP in the same cycle; that STOP gets `cmd_err`.
- `cycle_cnt` increments on every non-reset `dp_en` cycle and saturates at all ones.
- Mid-operation `rst`: every output takes its reset value at the next edge, and any in-flight STEP is discarded.

## Timing
- All outputs are registered.
- A command accepted at edge k causes `dp_en` (or `dp_rst`) to rise at edge k+1.
- STEP N: `dp_en` is high for exactly N consecutive cycles, `done` pulses in the cycle after the last one, and `cmd_ready` returns to 1 in that same cycle.
- RUN then STOP accepted at edge k: `dp_en` falls at edge k+1, together with the `done` pulse.
- Halt sampled at edge k: `dp_en` falls at k+1, with `halted`=1 and `done` pulsing. The enabled cycle at k is counted.
- DPRST: `dp_rst` is high for RST_CYC cycles starting at k+1, and `cmd_ready`=1 at k+RST_CYC+1.
- Back-to-back commands: a command can be accepted in the same cycle `done` pulses.

## Configuration
- `DP_RUN_CTRL_WDOG_EN` defined:
  - A counter of consecutive RUN cycles is cleared on RUN entry.
  - When the counter reaches WDOG_CYC, `dp_en` falls, the state goes to IDLE, and `done` and `wdog_trip` pulse together.
  - Halt or STOP on the same cycle wins, and `wdog_trip` stays 0.
- Not defined: there is no counter, `wdog_trip` is tied to 0, and RUN continues until halt or STOP.

## Test plan
- Reset, then STEP with `cmd_steps`=5 → `dp_en` high exactly 5 cycles starting 1 cycle after acceptance, `done` pulses once, and `cycle_cnt`=5.
- STEP with `cmd_steps`=0 → exactly 1 enable cycle and `cycle_cnt` +1.
- RUN, then `dp_halt`=1 on the 20th enabled cycle, with a STOP presented the same cycle → `dp_en` falls next cycle, `halted`=1, `cmd_err` pulses, and `cycle_cnt`=20. A subsequent RUN gets `cmd_err`; a DPRESET gets `dp_rst` high for 4 cycles, then `cycle_cnt`=0, `halted`=0, and IDLE.
- RUN, then STOP after 100 cycles → `dp_en` falls the cycle after acceptance, `done` pulses, and `cycle_cnt`=100. A STOP in IDLE → `cmd_err` pulse only.
- Assert `rst` in the middle of STEP 1000 → the next cycle shows IDLE, `dp_en`=0, `cycle_cnt`=0, and `cmd_ready`=1.
- With `DP_RUN_CTRL_WDOG_EN` and `WDOG_CYC`=50: RUN with no halt → exactly 50 enable cycles, `wdog_trip` and `done` pulse, and IDLE. Without the macro → `dp_en` stays high past 50 cycles and `wdog_trip` stays 0.
